// File: rtl/imem_loader.sv
// Byte-stream loader for the 2048 x 8 instruction memory. It receives a framed image
// (sync, 16-bit length, payload, 8-bit sum) and writes the payload while the core is held in reset.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for SYNC_BYTE, other bytes dropped
//  LEN_LO | capture low length byte
//  LEN_HI | capture high length byte, range-check full length
//  DATA   | write payload bytes to consecutive addresses
//  CSUM   | compare received sum against running payload sum
//  DONE   | one-cycle success pulse, core released
//  ERR    | one-cycle failure, sticky error raised, core released
module imem_loader #(
    parameter int          ADDR_W    = 11,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Largest payload that fits between BASE_ADDR and the top of memory without wrapping.
    localparam logic [16:0]       LEN_MAX = 17'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_t      state, state_next;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [7:0]  csum;
    logic        acc;
    logic [15:0] len_full;

    assign in_ready  = (state != S_DONE) && (state != S_ERR);
    assign acc       = in_valid && in_ready;
    assign len_full  = {in_data, len[7:0]};
    assign cpu_hold  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign load_done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (acc && (in_data == SYNC_BYTE)) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (acc) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (acc) begin
                    if ({1'b0, len_full} > LEN_MAX) state_next = S_ERR;
                    else if (len_full == 16'd0)     state_next = S_CSUM;
                    else                            state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (acc && (cnt == len - 16'd1)) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (acc) state_next = (in_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= 8'd0;
            load_err  <= 1'b0;
            len       <= 16'd0;
            cnt       <= 16'd0;
            csum      <= 8'd0;
        end else begin
            mem_we <= (state == S_DATA) && acc;
            if (state_next == S_ERR) load_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (acc && (in_data == SYNC_BYTE)) begin
                        cnt      <= 16'd0;
                        csum     <= 8'd0;
                        load_err <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (acc) len[7:0] <= in_data;
                end
                S_LEN_HI: begin
                    if (acc) len[15:8] <= in_data;
                end
                S_DATA: begin
                    if (acc) begin
                        mem_waddr <= BASE + cnt[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        cnt       <= cnt + 16'd1;
                        csum      <= csum + in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes go into a queue as payload
// bytes are driven and are popped as the DUT issues write strobes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [10:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [18:0] exp_q[$];
    logic [7:0]  mem_model [0:2047];
    logic [7:0]  pay [0:2047];
    int          writes   = 0;
    int          notready = 0;
    int          dones    = 0;
    logic [10:0] last_addr = '0;
    bit          rand_gaps = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard consumer, sampled away from the active edge.
    always @(negedge clk) begin
        if (in_ready === 1'b0) notready++;
        if (load_done === 1'b1) dones++;
        if (mem_we === 1'b1) begin
            writes++;
            last_addr = mem_waddr;
            mem_model[mem_waddr] = mem_wdata;
            if (exp_q.size() == 0) check("unexpected_write", 32'(exp_q.size()), 32'd1);
            else check("write", 32'({mem_waddr, mem_wdata}), 32'(exp_q.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (rand_gaps) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit bad);
        logic [7:0] cs;
        cs = 8'd0;
        send_byte(8'hA5);
        check("hold_after_sync", 32'(cpu_hold), 32'd1);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({i[10:0], pay[i]});
            cs = 8'(cs + pay[i]);
            send_byte(pay[i]);
        end
        check("hold_before_csum", 32'(cpu_hold), 32'd1);
        send_byte(bad ? 8'(cs + 8'd1) : cs);
        check("done_pulse", 32'(load_done), 32'(!bad));
        check("err_flag", 32'(load_err), 32'(bad));
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("ready_low_end", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(load_done), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_prog1();
        pay[0] = 8'h93; pay[1] = 8'h00; pay[2] = 8'h10; pay[3] = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-byte program
        load_prog1();
        writes = 0; notready = 0;
        send_frame(4, 1'b0);
        check("t1_word0", {mem_model[3], mem_model[2], mem_model[1], mem_model[0]}, 32'h00100093);
        check("t1_writes", 32'(writes), 32'd4);
        check("t1_notready", 32'(notready), 32'd1);

        // Bad checksum: writes still happen, error raised, next sync clears it
        writes = 0;
        send_frame(4, 1'b1);
        check("t2_writes", 32'(writes), 32'd4);
        send_byte(8'hA5);
        check("t2_err_cleared", 32'(load_err), 32'd0);

        // Oversized length (2049) errors right after the length
        send_byte(8'h01);
        send_byte(8'h08);
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_ready_low", 32'(in_ready), 32'd0);
        check("t3_no_done", 32'(load_done), 32'd0);
        @(negedge clk);
        check("t3_no_writes", 32'(writes), 32'd4);

        // Full memory image, last address 0x7FF
        for (int i = 0; i < 2048; i++) pay[i] = 8'($urandom);
        writes = 0;
        send_frame(2048, 1'b0);
        check("t3_full_writes", 32'(writes), 32'd2048);
        check("t3_last_addr", 32'(last_addr), 32'h7FF);

        // Junk before sync, then empty frame
        writes = 0; dones = 0;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t4_idle_hold", 32'(cpu_hold), 32'd0);
        send_frame(0, 1'b0);
        check("t4_zero_writes", 32'(writes), 32'd0);
        check("t4_dones", 32'(dones), 32'd1);

        // Reset mid-frame
        load_prog1();
        writes = 0;
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        exp_q.push_back({11'd0, 8'h93});
        send_byte(8'h93);
        exp_q.push_back({11'd1, 8'h00});
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        check("t5_waddr", 32'(mem_waddr), 32'd0);
        check("t5_wdata", 32'(mem_wdata), 32'd0);
        check("t5_hold", 32'(cpu_hold), 32'd0);
        check("t5_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'hA3);
        repeat (2) @(negedge clk);
        check("t5_writes", 32'(writes), 32'd2);
        check("t5_hold_idle", 32'(cpu_hold), 32'd0);
        send_frame(4, 1'b0);
        check("t5_reload_writes", 32'(writes), 32'd6);

        // Random in_valid gaps
        rand_gaps = 1'b1;
        writes = 0; notready = 0;
        send_frame(4, 1'b0);
        rand_gaps = 1'b0;
        check("t6_writes", 32'(writes), 32'd4);
        check("t6_notready", 32'(notready), 32'd1);
        check("t6_word0", {mem_model[3], mem_model[2], mem_model[1], mem_model[0]}, 32'h00100093);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
